// File: rtl/bit_serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_serial_adder_pkg : shared state encoding and default width       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package bit_serial_adder_pkg;

   localparam int SERIAL_ADD_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_1_constructure.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_1_constructure : 1-bit full-adder cell                         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module adder_1_constructure (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_serial_adder : WIDTH-bit adder, one full-adder cell, LSB first   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_msb  = CNT_W'(WIDTH - 2);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic               r_carry;
   logic               r_msb_cin;
   logic [CNT_W-1:0]   r_count;
   logic               w_s;
   logic               w_cout;

   adder_1_constructure u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_a_sh    <= '0;
         r_b_sh    <= '0;
         r_carry   <= 1'b0;
         r_msb_cin <= 1'b0;
         r_count   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_carry  <= cin;
                  r_count  <= '0;
                  sum      <= '0;
                  cout     <= 1'b0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum     <= {w_s, sum[WIDTH-1:1]};
               r_carry <= w_cout;
               r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_count <= r_count + CNT_W'(1);
               // carry leaving bit WIDTH-2 is the carry into the MSB
               if (r_count == c_msb) begin
                  r_msb_cin <= w_cout;
               end
               if (r_count == c_last) begin
                  cout     <= w_cout;
                  overflow <= r_msb_cin ^ w_cout;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bit_serial_adder : directed and random checks, 8- and 16-bit DUTs |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bit_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start16;
   logic [7:0]  a8, b8, sum8;
   logic [15:0] a16, b16, sum16;
   logic        cin8, cin16;
   logic        busy8, done8, cout8, ovf8;
   logic        busy16, done16, cout16, ovf16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
   );

   bit_serial_adder #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference: plain integer addition plus the two's-complement sign rule
   function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic c, output logic [31:0] s,
                                 output logic co, output logic ov);
      longint unsigned full;
      longint unsigned mask;
      full = longint'(x) + longint'(y) + longint'(c);
      mask = (64'd1 << w) - 64'd1;
      s    = 32'(full & mask);
      co   = 1'((full >> w) & 64'd1);
      ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
   endfunction

   function automatic logic busy_of(input int which);
      return (which == 8) ? busy8 : busy16;
   endfunction
   function automatic logic done_of(input int which);
      return (which == 8) ? done8 : done16;
   endfunction
   function automatic logic [31:0] sum_of(input int which);
      return (which == 8) ? {24'b0, sum8} : {16'b0, sum16};
   endfunction
   function automatic logic cout_of(input int which);
      return (which == 8) ? cout8 : cout16;
   endfunction
   function automatic logic ovf_of(input int which);
      return (which == 8) ? ovf8 : ovf16;
   endfunction

   task automatic run_op(input int which, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic [31:0] es, input logic ec,
                         input logic eo, input string tag);
      int n;
      int nbusy;
      if (which == 8) begin
         a8 = x[7:0]; b8 = y[7:0]; cin8 = c; start8 = 1'b1;
      end else begin
         a16 = x[15:0]; b16 = y[15:0]; cin16 = c; start16 = 1'b1;
      end
      tick();
      start8 = 1'b0; start16 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      nbusy = busy_of(which) ? 1 : 0;
      n = 0;
      while (!done_of(which) && n < 4 * which) begin
         tick();
         n++;
         if (busy_of(which)) nbusy++;
      end
      check({tag, ".latency"}, 64'(n), 64'(which));
      check({tag, ".busy_cycles"}, 64'(nbusy), 64'(which));
      check({tag, ".sum"}, 64'(sum_of(which)), 64'(es));
      check({tag, ".cout"}, 64'(cout_of(which)), 64'(ec));
      check({tag, ".overflow"}, 64'(ovf_of(which)), 64'(eo));
      tick();
      check({tag, ".done_pulse"}, 64'(done_of(which)), 64'(0));
      check({tag, ".sum_hold"}, 64'(sum_of(which)), 64'(es));
   endtask

   initial begin
      logic [31:0] rx, ry, es;
      logic        rc, ec, eo;
      int          prev, ndone;
      logic        seen_done;

      rst = 1'b1;
      start8 = 1'b0; start16 = 1'b0;
      a8 = '0; b8 = '0; cin8 = 1'b0;
      a16 = '0; b16 = '0; cin16 = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst.busy", 64'(busy8), 64'(0));
         check("rst.done", 64'(done8), 64'(0));
         check("rst.sum", 64'(sum8), 64'(0));
         check("rst.cout", 64'(cout8), 64'(0));
         check("rst.ovf", 64'(ovf8), 64'(0));
      end
      check("rst.sum16", 64'(sum16), 64'(0));
      check("rst.busy16", 64'(busy16), 64'(0));

      // directed arithmetic corners
      run_op(8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, "ff_01");
      run_op(8, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, "7f_01");
      run_op(8, 32'hA5, 32'h5A, 1'b1, 32'h00, 1'b1, 1'b0, "a5_5a_c");
      run_op(8, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1, "80_80");

      // start held high: one result every WIDTH+2 cycles
      a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      prev = -1; ndone = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (busy8) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         end else begin
            a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
         end
         if (done8) begin
            check("held.sum", 64'(sum8), 64'h10);
            if (prev >= 0) check("held.period", 64'(i - prev), 64'(10));
            prev = i;
            ndone++;
         end
      end
      check("held.count", 64'(ndone), 64'(6));
      start8 = 1'b0;
      tick();

      // reset wins over start
      a8 = 8'h11; b8 = 8'h22; start8 = 1'b1; rst = 1'b1;
      tick();
      check("rst_start.busy", 64'(busy8), 64'(0));
      rst = 1'b0; start8 = 1'b0;
      tick();

      // abort at the 4th RUN edge
      a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.busy", 64'(busy8), 64'(0));
      check("abort.done", 64'(done8), 64'(0));
      check("abort.sum", 64'(sum8), 64'(0));
      check("abort.cout", 64'(cout8), 64'(0));
      check("abort.ovf", 64'(ovf8), 64'(0));
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) seen_done = 1'b1;
      end
      check("abort.no_done", 64'(seen_done), 64'(0));
      run_op(8, 32'h3C, 32'h42, 1'b0, 32'h7E, 1'b0, 1'b0, "after_abort");

      // random operations on both widths
      for (int i = 0; i < 200; i++) begin
         rx = 32'($urandom_range(0, 255));
         ry = 32'($urandom_range(0, 255));
         rc = 1'($urandom);
         model(8, rx, ry, rc, es, ec, eo);
         run_op(8, rx, ry, rc, es, ec, eo, "rand8");
      end
      for (int i = 0; i < 200; i++) begin
         rx = 32'($urandom_range(0, 65535));
         ry = 32'($urandom_range(0, 65535));
         rc = 1'($urandom);
         model(16, rx, ry, rc, es, ec, eo);
         run_op(16, rx, ry, rc, es, ec, eo, "rand16");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-bit adder that reuses one 1-bit full-adder cell over WIDTH clock cycles, LSB first, with a registered carry between bits.
- Sits directly downstream of the 1-bit full-adder cell and consumes its s/cout every cycle, sequencing it into a WIDTH-bit result.
- Uses a start/busy/done handshake so a controller or testbench can issue one addition at a time.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- On rst: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, count=0, carry=0, shift registers=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle.
- IDLE -> RUN: on edge E0 with start=1.
  - Load a_sh<=a, b_sh<=b, carry<=cin, count<=0.
  - Clear sum, cout and overflow at this edge.
- Each RUN edge:
  - Full-adder inputs are a_sh[0], b_sh[0], carry.
  - sum <= {s, sum[WIDTH-1:1]}, i.e. shift in at the MSB.
  - carry <= cout_cell.
  - a_sh and b_sh shift right by one.
  - count <= count+1.
  - On the edge where count==WIDTH-2: record carry as msb_cin, the carry into the MSB.
- RUN -> DONE: on the edge where count==WIDTH-1, i.e. the WIDTH-th RUN edge (E_WIDTH).
  - That same edge sets cout<=cout_cell and overflow<=msb_cin^cout_cell.
- DONE -> IDLE: unconditionally on the next edge.
- Timing:
  - busy is high from E0 through E_WIDTH (WIDTH cycles).
  - done is high from E_WIDTH to E_WIDTH+1.
  - Latency is start-edge to done = WIDTH clocks.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is accepted on the edge after done falls, when the state is IDLE again.
- start in RUN or DONE is ignored; it is neither queued nor an error.
- a, b and cin may change freely after E0 without affecting the result.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1).
- rst asserted mid-RUN or in DONE aborts the operation. On the next cycle all outputs equal their reset values and no done pulse occurs.
- rst and start both high: rst wins.
- count is sized $clog2(WIDTH) bits, minimum 1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default width constant SERIAL_ADD_WIDTH=8.
- One sub-module: instantiate the existing 1-bit full-adder cell adder_1_constructure (ports a, b, cin, s, cout) as the only combinational datapath.
- Control FSM, counter and shift registers stay in this module.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, sum=0x00, cout=0, overflow=0 throughout.
- a=0xFF, b=0x01, cin=0, start one cycle -> busy high 8 cycles; done 8 clocks after the start edge; sum=0x00, cout=1, overflow=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, overflow=0.
- start held high continuously with a=0x0F, b=0x01, cin=0 -> exactly one done per WIDTH+2 cycles, each with sum=0x10; changes to a/b during RUN do not alter the result.
- Start a=0x3C, b=0x42, assert rst for one cycle at the 4th RUN edge -> next cycle busy=0, done=0, sum=0; no done pulse. A fresh start then yields sum=0x7E.
- 200 random operations with WIDTH=8 and WIDTH=16 -> every done pulse matches a reference model of {cout,sum}=a+b+cin and the signed-overflow rule.
